// File: rtl/mps_analog_intl_gen.sv
// Analog interlock generator: per-channel window compare on a serial ADC stream,
// consecutive-violation debounce, latched fault/direction vector and first-fault capture.
module mps_analog_intl_gen #(
  parameter int NUM_CH   = 18,
  parameter int DATA_W   = 16,
  parameter int DEBOUNCE = 3,
  parameter int CH_W     = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adc_valid,
  input  logic [CH_W-1:0]   i_adc_ch,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_thr_we,
  input  logic [CH_W:0]     i_thr_addr,
  input  logic [DATA_W-1:0] i_thr_data,
  input  logic [NUM_CH-1:0] i_intl_mask,
  input  logic              i_intl_clr,
  output logic [NUM_CH-1:0] o_analog_intl,
  output logic [NUM_CH-1:0] o_intl_dir,
  output logic [CH_W-1:0]   o_first_fault,
  output logic              o_first_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic signed [DATA_W-1:0] THR_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] THR_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] r_thr_hi [NUM_CH];
  logic signed [DATA_W-1:0] r_thr_lo [NUM_CH];
  logic [CNT_W-1:0]         r_cnt    [NUM_CH];
  logic [NUM_CH-1:0]        r_intl;
  logic [NUM_CH-1:0]        r_dir;
  logic [CH_W-1:0]          r_first_ch;
  logic                     r_first_vld;

  logic [CH_W-1:0]   w_thr_ch;
  logic              w_thr_ok;
  logic              w_smp_ok;
  logic              w_over;
  logic              w_under;
  logic              w_hold;
  logic              w_latch;
  logic [CNT_W-1:0]  w_cnt_cur;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_thr_ch = i_thr_addr[CH_W:1];
  assign w_thr_ok = i_thr_we && (w_thr_ch <= LAST_CH);
  assign w_smp_ok = i_adc_valid && (i_adc_ch <= LAST_CH);

  // Reads see the pre-write thresholds, so a same-cycle write never affects this sample.
  always_comb begin
    w_over    = 1'b0;
    w_under   = 1'b0;
    w_hold    = 1'b0;
    w_cnt_cur = '0;
    if (w_smp_ok) begin
      w_over    = $signed(i_adc_data) > r_thr_hi[i_adc_ch];
      w_under   = $signed(i_adc_data) < r_thr_lo[i_adc_ch];
      w_hold    = i_intl_mask[i_adc_ch] | r_intl[i_adc_ch];
      w_cnt_cur = r_cnt[i_adc_ch];
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (!w_hold && (w_over || w_under))
      w_cnt_nxt = (w_cnt_cur == CNT_MAX) ? CNT_MAX : w_cnt_cur + 1'b1;
  end

  assign w_latch = w_smp_ok && !w_hold && (w_over || w_under) && (w_cnt_cur == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_thr_hi[i] <= THR_MAX;
        r_thr_lo[i] <= THR_MIN;
        r_cnt[i]    <= '0;
      end
      r_intl      <= '0;
      r_dir       <= '0;
      r_first_ch  <= '0;
      r_first_vld <= 1'b0;
    end else begin
      if (w_thr_ok) begin
        if (i_thr_addr[0]) r_thr_hi[w_thr_ch] <= $signed(i_thr_data);
        else               r_thr_lo[w_thr_ch] <= $signed(i_thr_data);
      end
      if (i_intl_clr) begin
        for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        r_intl      <= '0;
        r_dir       <= '0;
        r_first_ch  <= '0;
        r_first_vld <= 1'b0;
      end else if (w_smp_ok) begin
        r_cnt[i_adc_ch] <= w_cnt_nxt;
        if (w_latch) begin
          r_intl[i_adc_ch] <= 1'b1;
          r_dir[i_adc_ch]  <= w_over;
          if (!r_first_vld) begin
            r_first_ch  <= i_adc_ch;
            r_first_vld <= 1'b1;
          end
        end
      end
    end
  end

  assign o_analog_intl = r_intl;
  assign o_intl_dir    = r_dir;
  assign o_first_fault = r_first_ch;
  assign o_first_valid = r_first_vld;

endmodule

// File: tb/tb_mps_analog_intl_gen.sv
// Self-checking bench for mps_analog_intl_gen: behavioural model feeds an expected-value
// queue per driven cycle; directed checks pin down the key scenarios.
module tb_mps_analog_intl_gen;
  localparam int NUM_CH = 18;
  localparam int DATA_W = 16;
  localparam int DB     = 3;
  localparam int CH_W   = 5;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_adc_valid;
  logic [CH_W-1:0]   i_adc_ch;
  logic [DATA_W-1:0] i_adc_data;
  logic              i_thr_we;
  logic [CH_W:0]     i_thr_addr;
  logic [DATA_W-1:0] i_thr_data;
  logic [NUM_CH-1:0] i_intl_mask;
  logic              i_intl_clr;
  logic [NUM_CH-1:0] o_analog_intl;
  logic [NUM_CH-1:0] o_intl_dir;
  logic [CH_W-1:0]   o_first_fault;
  logic              o_first_valid;

  mps_analog_intl_gen #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE(DB), .CH_W(CH_W)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_adc_valid(i_adc_valid), .i_adc_ch(i_adc_ch),
    .i_adc_data(i_adc_data), .i_thr_we(i_thr_we), .i_thr_addr(i_thr_addr),
    .i_thr_data(i_thr_data), .i_intl_mask(i_intl_mask), .i_intl_clr(i_intl_clr),
    .o_analog_intl(o_analog_intl), .o_intl_dir(o_intl_dir),
    .o_first_fault(o_first_fault), .o_first_valid(o_first_valid)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int                m_hi [NUM_CH];
  int                m_lo [NUM_CH];
  int                m_cnt[NUM_CH];
  logic [NUM_CH-1:0] m_intl;
  logic [NUM_CH-1:0] m_dir;
  logic [CH_W-1:0]   m_ff;
  logic              m_fv;

  typedef struct packed {
    logic [NUM_CH-1:0] intl;
    logic [NUM_CH-1:0] dir;
    logic [CH_W-1:0]   ff;
    logic              fv;
  } exp_t;
  exp_t q_exp[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_hi[i] = 32767; m_lo[i] = -32768; m_cnt[i] = 0;
    end
    m_intl = '0; m_dir = '0; m_ff = '0; m_fv = 1'b0;
  endtask

  // One clock cycle: drive, predict, push; then pop after the edge and compare.
  task automatic cyc(input logic v, input int ch, input int data,
                     input logic we, input int waddr, input int wdata, input logic clr);
    exp_t e, got;
    int sd;
    bit ov, un;
    i_adc_valid = v;
    i_adc_ch    = CH_W'(ch);
    i_adc_data  = DATA_W'(data);
    i_thr_we    = we;
    i_thr_addr  = (CH_W+1)'(waddr);
    i_thr_data  = DATA_W'(wdata);
    i_intl_clr  = clr;
    sd = data;
    if (clr) begin
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_intl = '0; m_dir = '0; m_ff = '0; m_fv = 1'b0;
    end else if (v && ch < NUM_CH) begin
      ov = sd > m_hi[ch];
      un = sd < m_lo[ch];
      if (i_intl_mask[ch] || m_intl[ch]) m_cnt[ch] = 0;
      else if (ov || un) begin
        if (m_cnt[ch] < DB) m_cnt[ch]++;
        if (m_cnt[ch] == DB) begin
          m_intl[ch] = 1'b1;
          m_dir[ch]  = ov;
          if (!m_fv) begin m_ff = CH_W'(ch); m_fv = 1'b1; end
        end
      end else m_cnt[ch] = 0;
    end
    if (we && (waddr >> 1) < NUM_CH) begin
      if (waddr[0]) m_hi[waddr >> 1] = wdata;
      else          m_lo[waddr >> 1] = wdata;
    end
    e.intl = m_intl; e.dir = m_dir; e.ff = m_ff; e.fv = m_fv;
    q_exp.push_back(e);
    @(posedge i_clk);
    #1;
    i_adc_valid = 1'b0; i_thr_we = 1'b0; i_intl_clr = 1'b0;
    got = q_exp.pop_front();
    check_val("intl",  64'(o_analog_intl), 64'(got.intl));
    check_val("dir",   64'(o_intl_dir),    64'(got.dir));
    check_val("first", 64'({o_first_valid, o_first_fault}), 64'({got.fv, got.ff}));
  endtask

  task automatic smp(input int ch, input int data);
    cyc(1'b1, ch, data, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wthr(input int ch, input bit hi, input int val);
    cyc(1'b0, 0, 0, 1'b1, ch * 2 + int'(hi), val, 1'b0);
  endtask

  initial begin
    i_rst = 1'b0; i_adc_valid = 1'b0; i_adc_ch = '0; i_adc_data = '0;
    i_thr_we = 1'b0; i_thr_addr = '0; i_thr_data = '0; i_intl_mask = '0; i_intl_clr = 1'b0;
    model_reset();
    #23;
    check_val("rst_intl",  64'(o_analog_intl), 64'h0);
    check_val("rst_dir",   64'(o_intl_dir), 64'h0);
    check_val("rst_first", 64'({o_first_valid, o_first_fault}), 64'h0);
    @(negedge i_clk); i_rst = 1'b1;
    @(posedge i_clk); #1;

    // extremes never trip default thresholds
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NUM_CH; c++) begin smp(c, 32767); smp(c, -32768); end
    check_val("dflt_intl", 64'(o_analog_intl), 64'h0);
    check_val("dflt_fv",   64'(o_first_valid), 64'h0);

    // ch3 over-limit
    wthr(3, 1'b1, 1000);
    smp(3, 1001); smp(3, 1000); smp(3, 1001); smp(3, 1001);
    check_val("ch3_pre", 64'(o_analog_intl[3]), 64'h0);
    smp(3, 1001);
    check_val("ch3_set", 64'(o_analog_intl[3]), 64'h1);
    check_val("ch3_dir", 64'(o_intl_dir[3]), 64'h1);
    check_val("ch3_ff",  64'({o_first_valid, o_first_fault}), 64'({1'b1, 5'd3}));

    // ch5 under-limit with interleaved other channels and equal-threshold samples
    wthr(5, 1'b0, -500);
    for (int k = 0; k < 4; k++) smp(5, -500);
    smp(5, -501); smp(4, -30000); smp(5, -501); smp(5, -400);
    smp(5, -501); smp(6, 5); smp(5, -501);
    check_val("ch5_pre", 64'(o_analog_intl[5]), 64'h0);
    smp(5, -501);
    check_val("ch5_set", 64'(o_analog_intl[5]), 64'h1);
    check_val("ch5_dir", 64'(o_intl_dir[5]), 64'h0);

    // ch7 latches later; first fault remains 3; clear with simultaneous violation
    wthr(7, 1'b1, 100);
    smp(7, 200); smp(7, 200); smp(7, 200);
    check_val("ch7_set", 64'(o_analog_intl[7]), 64'h1);
    check_val("ff_keep", 64'(o_first_fault), 64'd3);
    cyc(1'b1, 7, 200, 1'b0, 0, 0, 1'b1);
    check_val("clr_intl", 64'(o_analog_intl), 64'h0);
    check_val("clr_fv",   64'(o_first_valid), 64'h0);
    smp(7, 200); smp(7, 200);
    check_val("ch7_re_pre", 64'(o_analog_intl[7]), 64'h0);
    smp(7, 200);
    check_val("ch7_re", 64'(o_analog_intl[7]), 64'h1);
    check_val("ff_7", 64'({o_first_valid, o_first_fault}), 64'({1'b1, 5'd7}));

    // mask on ch9
    wthr(9, 1'b1, 0);
    i_intl_mask[9] = 1'b1;
    for (int k = 0; k < 5; k++) smp(9, 50);
    check_val("ch9_mask", 64'(o_analog_intl[9]), 64'h0);
    i_intl_mask[9] = 1'b0;
    smp(9, 50); smp(9, 50); smp(9, 50);
    check_val("ch9_set", 64'(o_analog_intl[9]), 64'h1);
    i_intl_mask[9] = 1'b1;
    smp(9, 0); smp(9, 50);
    check_val("ch9_hold", 64'(o_analog_intl[9]), 64'h1);
    i_intl_mask = '0;

    // same-cycle threshold write uses old value; out-of-range channel ignored
    cyc(1'b1, 2, 10, 1'b1, 5, 0, 1'b0);
    smp(2, 10); smp(2, 10);
    check_val("ch2_pre", 64'(o_analog_intl[2]), 64'h0);
    smp(20, 30000);
    cyc(1'b0, 0, 0, 1'b1, 41, 0, 1'b0);
    smp(2, 10);
    check_val("ch2_set", 64'(o_analog_intl[2]), 64'h1);
    check_val("ch2_dir", 64'(o_intl_dir[2]), 64'h1);

    // randomized traffic, scoreboard checked
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      int rc, rd;
      rc = int'($urandom_range(0, 19));
      rd = int'($urandom_range(0, 4000)) - 2000;
      i_intl_mask = NUM_CH'($urandom) & NUM_CH'($urandom);
      case ($urandom_range(0, 9))
        0:       cyc(1'b0, 0, 0, 1'b1, int'($urandom_range(0, 41)),
                     int'($urandom_range(0, 3000)) - 1500, 1'b0);
        1:       cyc(1'b1, rc, rd, 1'b0, 0, 0, ($urandom_range(0, 15) == 0));
        default: smp(rc, rd);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mps_analog_intl_gen.md
Name: mps_analog_intl_gen

Overview:
- Generates the 18-bit latched analog interlock vector consumed by the MPS system FSM interlock input (i_analog_intl), and responds to the system's interlock-clear pulse.
- Receives a time-multiplexed ADC sample stream (one channel per valid cycle) and compares each sample against per-channel high and low thresholds.
- Debounces consecutive violations per channel, latches the fault, and reports the first-fault channel for diagnostics.

Parameters:
NUM_CH, 18, number of monitored channels; sets the interlock vector width.
DATA_W, 16, ADC sample and threshold width; values are signed two's complement.
DEBOUNCE, 3, consecutive violating samples of one channel required to latch its fault; legal range is 1..255.
CH_W, 5, channel index width; must satisfy 2^CH_W >= NUM_CH.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_adc_valid  in  1  sample strobe; one sample is accepted per high cycle
i_adc_ch  in  CH_W  channel index of the sample
i_adc_data  in  DATA_W  signed sample value
i_thr_we  in  1  threshold write strobe
i_thr_addr  in  CH_W+1  {channel, sel}; sel=1 selects the high threshold, sel=0 the low threshold
i_thr_data  in  DATA_W  signed threshold value
i_intl_mask  in  NUM_CH  1 = channel is inhibited from latching new faults
i_intl_clr  in  1  clear pulse from the system block (o_intl_clr)
o_analog_intl  out  NUM_CH  latched fault vector
o_intl_dir  out  NUM_CH  direction of each latched fault; 1 = over-limit, 0 = under-limit
o_first_fault  out  CH_W  index of the first channel to latch since the last clear
o_first_valid  out  1  o_first_fault holds a valid capture

Behaviour:
- Reset is controlled by i_rst only: asynchronous, active-low, on clock i_clk.
- Reset values:
  - all outputs 0;
  - high thresholds = +max (0x7FFF for DATA_W=16); low thresholds = -max (0x8000); with these no channel can trip;
  - all debounce counters 0.
- Comparison is performed on a cycle where i_adc_valid=1 and i_adc_ch < NUM_CH:
  - over = data > high (strict);
  - under = data < low (strict);
  - a sample equal to a threshold is in range;
  - if both conditions are true (misconfigured low > high), over takes priority.
- Samples with i_adc_ch >= NUM_CH are ignored; no state changes.
- Debounce counter update per channel ch, applied only when that channel is sampled:
  - If ch is masked or already latched: counter is forced to 0.
  - Else, on a violation: counter increments, saturating at DEBOUNCE.
  - Else, on an in-range sample: counter resets to 0.
- Latch condition: the violating sample whose increment makes the counter reach DEBOUNCE sets o_analog_intl[ch] and writes o_intl_dir[ch].
  - Both outputs are registered and visible on the first clock edge after that sample cycle (latency 1).
  - Samples on other channels interleaved between a channel's samples do not affect that channel's counter.
- Latched bits hold until i_intl_clr. Later in-range samples and mask changes do not clear them. The mask blocks only new latching.
- First fault: when o_first_valid=0 and a latch occurs, o_first_fault <= ch and o_first_valid <= 1 in the same edge. Because samples are serial, two latches can never occur in one cycle. Later latches do not overwrite the capture.
- i_intl_clr (level; each high cycle acts):
  - next edge clears o_analog_intl, o_intl_dir, o_first_valid, o_first_fault and all counters;
  - a sample arriving in the same cycle is discarded; clear wins;
  - a persisting condition re-latches after DEBOUNCE further violating samples.
- Threshold writes:
  - take effect at the next edge;
  - a sample on the same channel in the same cycle compares against the old value;
  - writes do not alter counters or latches;
  - writes to channel >= NUM_CH are ignored.
- Storage: thresholds are held in 2*NUM_CH registers; an inferred distributed RAM with an asynchronous read port is acceptable. Counters are NUM_CH x $clog2(DEBOUNCE+1) bits.

Test Plan:
- Reset, then stream ch0..17 at 0x7FFF and 0x8000 → nothing latches; o_analog_intl=0, o_first_valid=0.
- Set ch3 high=1000, then send ch3 samples 1001, 1001, 1001 → bit3 set one cycle after the third sample; o_intl_dir[3]=1; o_first_fault=3, o_first_valid=1.
- Set ch5 low=-500, then send -501, -501, -400, -501, -501, -501 → no latch until the sixth sample; o_intl_dir[5]=0. Sending -500 (equal to the threshold) never counts.
- Latch ch3, then latch ch7 → o_first_fault stays 3. Pulse i_intl_clr together with a violating ch7 sample → all cleared. Three new ch7 violations → ch7 re-latches; o_first_fault=7.
- Set i_intl_mask[9]=1 and send five ch9 violations → no latch. Clear the mask, then send 3 violations → latches. Setting mask[9]=1 again keeps bit9 latched.
- Write ch2 high=0 in the same cycle as a ch2 sample of 10 → that sample uses the old +max (no count); the next 10 counts. A sample with ch=20 → ignored.
